router_pkt_gen: RTL and testbench

- Upstream packet source for the 1x3 router: frames a payload into the router's input protocol and drives pkt_valid/data bytes into the router input.
- Packet format: header byte {len[5:0], addr[1:0]}, then len payload bytes, then one parity byte (XOR of header and all payload bytes).
- Payload is first buffered in full, then streamed with no bubbles, because the router treats pkt_valid low as end of packet.
- Honours router busy and monitors router err.

---
 rtl/router_pkg.sv | 28 ++
 rtl/router_pkt_buf.sv | 62 ++++++
 rtl/router_pkt_gen.sv | 225 ++++++++++++++++++++++
 tb/tb_router_pkt_gen.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared definitions for the router packet generator.
//   state_e      : generator FSM states
//   ADDR_W/LEN_W/DATA_W : field widths of the router byte protocol
//   ILLEGAL_ADDR : destination value that has no router output port
//   pack_header  : header byte layout {len, addr}
package router_pkg;

  localparam int ADDR_W = 2;
  localparam int LEN_W  = 6;
  localparam int DATA_W = 8;

  localparam logic [ADDR_W-1:0] ILLEGAL_ADDR = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    HEADER,
    PAYLOAD,
    PARITY,
    GAP
  } state_e;

  function automatic logic [DATA_W-1:0] pack_header(input logic [LEN_W-1:0]  len,
                                                    input logic [ADDR_W-1:0] addr);
    return {len, addr};
  endfunction

endpackage

// File: rtl/router_pkt_buf.sv
// Payload staging buffer: 64 x 8 simple write/read store.
// Ports:
//   clock, reset     : rising-edge clock, synchronous active-high reset
//   clear            : return both pointers to 0 (start of a new packet)
//   wr_en, wr_data   : write wr_data at wr_ptr, then advance wr_ptr
//   rd_en            : advance rd_ptr
//   rd_data          : contents at rd_ptr (combinational read)
//   wr_ptr, rd_ptr   : current pointer values
module router_pkt_buf
  import router_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic [$clog2(DEPTH)-1:0] wr_ptr,
  output logic [$clog2(DEPTH)-1:0] rd_ptr
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: a packet only reads locations it has written.
  always_ff @(posedge clock) begin
    if (wr_en && !clear) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign wr_ptr  = wr_ptr_q;
  assign rd_ptr  = rd_ptr_q;

endmodule

// File: rtl/router_pkt_gen.sv
// Upstream packet source for the 1x3 router.
// Accepts a command (dest_addr, pay_len), buffers the whole payload, then
// streams header, payload and parity to the router with no bubbles, since
// the router treats pkt_valid low as end of packet.
//
// Optional feature macro: ROUTER_PKT_GEN_PARITY_CORRUPT_EN adds input
// 'corrupt', latched with start; when set, the sent parity is flipped in bit 0.
//
// Ports:
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   start, dest_addr,
//   pay_len, corrupt      : command, sampled only while cmd_ready=1
//   cmd_ready             : idle, command accepted
//   cmd_err               : one-cycle pulse, command rejected
//   pay_data, pay_valid,
//   pay_ready             : payload byte input
//   busy, err             : router busy / parity error flag
//   pkt_valid, data_out   : router byte interface
//   done                  : one-cycle pulse at the end of the inter-packet gap
//   pkt_cnt               : packets sent (wraps)
//   err_cnt               : err rising edges (saturates at 255)
//   state_dbg             : current FSM state
//
// Handshakes: a payload byte transfers on a rising edge where
// pay_valid & pay_ready = 1; a router byte (header, payload or parity)
// transfers on a rising edge where it is presented and busy = 0, and the
// presented byte is held unchanged while busy = 1.
module router_pkt_gen
  import router_pkg::*;
#(
  parameter int MAX_LEN    = 63,
  parameter int GAP_CYCLES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] dest_addr,
  input  logic [LEN_W-1:0]  pay_len,
`ifdef ROUTER_PKT_GEN_PARITY_CORRUPT_EN
  input  logic              corrupt,
`endif
  output logic              cmd_ready,
  output logic              cmd_err,
  input  logic [DATA_W-1:0] pay_data,
  input  logic              pay_valid,
  output logic              pay_ready,
  input  logic              busy,
  input  logic              err,
  output logic              pkt_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              done,
  output logic [7:0]        pkt_cnt,
  output logic [7:0]        err_cnt,
  output state_e            state_dbg
);

  localparam int GAP_W = 4;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [DATA_W-1:0]  parity_q, parity_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [7:0]         pkt_cnt_q, pkt_cnt_d;
  logic [7:0]         err_cnt_q, err_cnt_d;
  logic               err_q, err_d;
  logic               cmd_err_q, cmd_err_d;
`ifdef ROUTER_PKT_GEN_PARITY_CORRUPT_EN
  logic               corrupt_q, corrupt_d;
`endif

  logic               buf_clear, buf_wr, buf_rd;
  logic [DATA_W-1:0]  buf_rd_data;
  logic [LEN_W-1:0]   buf_wr_ptr, buf_rd_ptr;
  logic [DATA_W-1:0]  header_byte;
  logic [DATA_W-1:0]  parity_tx;
  logic               cmd_ok;
  logic [LEN_W-1:0]   last_idx;

  router_pkt_buf #(.DEPTH(64)) u_buf (
    .clock   (clock),
    .reset   (reset),
    .clear   (buf_clear),
    .wr_en   (buf_wr),
    .wr_data (pay_data),
    .rd_en   (buf_rd),
    .rd_data (buf_rd_data),
    .wr_ptr  (buf_wr_ptr),
    .rd_ptr  (buf_rd_ptr)
  );

  assign header_byte = pack_header(len_q, addr_q);
  assign last_idx    = len_q - LEN_W'(1);
  assign cmd_ok      = (dest_addr != ILLEGAL_ADDR) && (pay_len != '0) &&
                       (int'(pay_len) <= MAX_LEN);

`ifdef ROUTER_PKT_GEN_PARITY_CORRUPT_EN
  assign parity_tx = parity_q ^ {{(DATA_W-1){1'b0}}, corrupt_q};
`else
  assign parity_tx = parity_q;
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    parity_d  = parity_q;
    gap_cnt_d = gap_cnt_q;
    pkt_cnt_d = pkt_cnt_q;
    cmd_err_d = 1'b0;
`ifdef ROUTER_PKT_GEN_PARITY_CORRUPT_EN
    corrupt_d = corrupt_q;
`endif
    buf_clear = 1'b0;
    buf_wr    = 1'b0;
    buf_rd    = 1'b0;
    cmd_ready = 1'b0;
    pay_ready = 1'b0;
    pkt_valid = 1'b0;
    data_out  = '0;
    done      = 1'b0;

    // err monitor runs in every state
    err_d     = err;
    err_cnt_d = err_cnt_q;
    if (err && !err_q && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;

    unique case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (start) begin
          if (cmd_ok) begin
            addr_d    = dest_addr;
            len_d     = pay_len;
            parity_d  = '0;
            buf_clear = 1'b1;
`ifdef ROUTER_PKT_GEN_PARITY_CORRUPT_EN
            corrupt_d = corrupt;
`endif
            state_d   = LOAD;
          end else begin
            cmd_err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        pay_ready = 1'b1;
        if (pay_valid) begin
          buf_wr   = 1'b1;
          parity_d = parity_q ^ pay_data;
          if (buf_wr_ptr == last_idx) state_d = HEADER;
        end
      end
      HEADER: begin
        pkt_valid = 1'b1;
        data_out  = header_byte;
        if (!busy) begin
          parity_d = parity_q ^ header_byte;
          state_d  = PAYLOAD;
        end
      end
      PAYLOAD: begin
        pkt_valid = 1'b1;
        data_out  = buf_rd_data;
        if (!busy) begin
          buf_rd = 1'b1;
          if (buf_rd_ptr == last_idx) state_d = PARITY;
        end
      end
      PARITY: begin
        data_out = parity_tx;
        if (!busy) begin
          gap_cnt_d = '0;
          state_d   = GAP;
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
          done      = 1'b1;
          pkt_cnt_d = pkt_cnt_q + 8'd1;
          state_d   = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      parity_q  <= '0;
      gap_cnt_q <= '0;
      pkt_cnt_q <= '0;
      err_cnt_q <= '0;
      err_q     <= 1'b0;
      cmd_err_q <= 1'b0;
`ifdef ROUTER_PKT_GEN_PARITY_CORRUPT_EN
      corrupt_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      parity_q  <= parity_d;
      gap_cnt_q <= gap_cnt_d;
      pkt_cnt_q <= pkt_cnt_d;
      err_cnt_q <= err_cnt_d;
      err_q     <= err_d;
      cmd_err_q <= cmd_err_d;
`ifdef ROUTER_PKT_GEN_PARITY_CORRUPT_EN
      corrupt_q <= corrupt_d;
`endif
    end
  end

  assign cmd_err   = cmd_err_q;
  assign pkt_cnt   = pkt_cnt_q;
  assign err_cnt   = err_cnt_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_router_pkt_gen.sv
`timescale 1ns/1ps
module tb_router_pkt_gen;
  import router_pkg::*;

  localparam int MAX_LEN    = 63;
  localparam int GAP_CYCLES = 2;

  // ---------------- clock / reset ----------------
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  always #5 clock = ~clock;

  logic       start = 1'b0;
  logic [1:0] dest_addr = '0;
  logic [5:0] pay_len = '0;
`ifdef ROUTER_PKT_GEN_PARITY_CORRUPT_EN
  logic       corrupt = 1'b0;
`endif
  logic       cmd_ready, cmd_err, pay_ready;
  logic [7:0] pay_data = '0;
  logic       pay_valid = 1'b0;
  logic       busy = 1'b0;
  logic       err = 1'b0;
  logic       pkt_valid, done;
  logic [7:0] data_out, pkt_cnt, err_cnt;
  state_e     state_dbg;

  router_pkt_gen #(.MAX_LEN(MAX_LEN), .GAP_CYCLES(GAP_CYCLES)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .dest_addr (dest_addr),
    .pay_len   (pay_len),
`ifdef ROUTER_PKT_GEN_PARITY_CORRUPT_EN
    .corrupt   (corrupt),
`endif
    .cmd_ready (cmd_ready),
    .cmd_err   (cmd_err),
    .pay_data  (pay_data),
    .pay_valid (pay_valid),
    .pay_ready (pay_ready),
    .busy      (busy),
    .err       (err),
    .pkt_valid (pkt_valid),
    .data_out  (data_out),
    .done      (done),
    .pkt_cnt   (pkt_cnt),
    .err_cnt   (err_cnt),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int         n_cmp = 0;
  int         n_fail = 0;
  logic [8:0] exp_q[$];      // {pkt_valid, data_out} of each router byte
  logic [7:0] pay_mem [64];
  int         exp_pkt_cnt = 0;
  int         exp_err_cnt = 0;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no end, required end of test");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic queue_packet(input logic [1:0] a, input int len, input logic corr);
    logic [7:0] hdr, par;
    hdr = {6'(len), a};
    par = hdr;
    exp_q.push_back({1'b1, hdr});
    for (int i = 0; i < len; i++) begin
      exp_q.push_back({1'b1, pay_mem[i]});
      par = par ^ pay_mem[i];
    end
    if (corr) par = par ^ 8'h01;
    exp_q.push_back({1'b0, par});
  endtask

  // Issues the command and loads the payload; returns at the negedge where
  // the header should be visible.
  task automatic load_packet(input logic [1:0] a, input int len, input int gap_at,
                             input int gap_len, input logic corr);
    int   i, gcnt, budget;
    logic activity;
    queue_packet(a, len, corr);
    @(negedge clock);
    start     = 1'b1;
    dest_addr = a;
    pay_len   = 6'(len);
`ifdef ROUTER_PKT_GEN_PARITY_CORRUPT_EN
    corrupt   = corr;
`endif
    @(negedge clock);
    start = 1'b0;
    i = 0; gcnt = 0; budget = 0; activity = 1'b0;
    while (i < len && budget < 1000) begin
      if (pkt_valid) activity = 1'b1;
      if (i == gap_at && gcnt < gap_len) begin
        pay_valid = 1'b0;
        gcnt++;
      end else begin
        pay_valid = 1'b1;
        pay_data  = pay_mem[i];
        if (pay_ready) i++;
      end
      @(negedge clock);
      budget++;
    end
    pay_valid = 1'b0;
    n_cmp++;
    if (i != len) begin
      n_fail++;
      $display("FAIL load_handshakes: got %0d bytes accepted, required %0d", i, len);
    end
    n_cmp++;
    if (activity) begin
      n_fail++;
      $display("FAIL load_quiet: got pkt_valid=1 during LOAD, required 0");
    end
  endtask

  // Observes the router interface until done, comparing every accepted
  // byte against the scoreboard. Byte index busy_idx is stalled busy_len cycles.
  task automatic collect(input int busy_idx, input int busy_len, input int exp_len);
    int         k, bcnt, cycles, stream_cyc, since_par;
    logic       in_pkt, done_seen;
    logic [8:0] obs, expv;
    k = 0; bcnt = 0; cycles = 0; stream_cyc = 0; since_par = -1;
    in_pkt = 1'b0; done_seen = 1'b0;
    while (!done_seen && cycles < 2000) begin
      if (k == busy_idx && bcnt < busy_len) begin
        busy = 1'b1;
        bcnt++;
      end else begin
        busy = 1'b0;
      end
      if (pkt_valid) in_pkt = 1'b1;
      if (in_pkt) begin
        stream_cyc++;
        obs = {pkt_valid, data_out};
        if (exp_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL stream_extra: got byte %h, required no more bytes", obs);
          in_pkt = 1'b0;
        end else if (busy) begin
          n_cmp++;
          if (obs !== exp_q[0]) begin
            n_fail++;
            $display("FAIL stream_hold: byte %0d got %h, required %h", k, obs, exp_q[0]);
          end
        end else begin
          expv = exp_q.pop_front();
          n_cmp++;
          if (obs !== expv) begin
            n_fail++;
            $display("FAIL stream_byte: byte %0d got %h, required %h", k, obs, expv);
          end
          if (!pkt_valid) begin
            in_pkt    = 1'b0;
            since_par = 0;
          end
          k++;
        end
      end else if (since_par >= 0) begin
        since_par++;
      end
      if (done) begin
        done_seen = 1'b1;
        n_cmp++;
        if (since_par != GAP_CYCLES || pkt_valid !== 1'b0 || data_out !== 8'h00) begin
          n_fail++;
          $display("FAIL done_timing: got %0d cycles after parity (pkt_valid=%b data=%h), required %0d (0, 00)",
                   since_par, pkt_valid, data_out, GAP_CYCLES);
        end
      end
      @(negedge clock);
      cycles++;
    end
    busy = 1'b0;
    n_cmp++;
    if (!done_seen) begin
      n_fail++;
      $display("FAIL done_timeout: got no done in %0d cycles, required a done pulse", cycles);
    end
    n_cmp++;
    if (k != exp_len + 2 || stream_cyc != exp_len + 2 + busy_len) begin
      n_fail++;
      $display("FAIL stream_length: got %0d bytes in %0d cycles, required %0d in %0d",
               k, stream_cyc, exp_len + 2, exp_len + 2 + busy_len);
    end
    exp_pkt_cnt++;
    n_cmp++;
    if (cmd_ready !== 1'b1 || state_dbg !== IDLE || done !== 1'b0 || pkt_cnt !== 8'(exp_pkt_cnt)) begin
      n_fail++;
      $display("FAIL post_packet: got cmd_ready=%b state=%0d done=%b pkt_cnt=%0d, required 1 %0d 0 %0d",
               cmd_ready, state_dbg, done, pkt_cnt, IDLE, 8'(exp_pkt_cnt));
    end
    exp_q.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    n_cmp++;
    if (cmd_ready !== 1'b1 || cmd_err !== 1'b0 || pay_ready !== 1'b0 || pkt_valid !== 1'b0 ||
        data_out !== 8'h00 || done !== 1'b0 || pkt_cnt !== 8'h00 || err_cnt !== 8'h00 ||
        state_dbg !== IDLE) begin
      n_fail++;
      $display("FAIL reset_values: got rdy=%b cerr=%b prdy=%b pv=%b d=%h done=%b pc=%0d ec=%0d st=%0d, required 1 0 0 0 00 0 0 0 %0d",
               cmd_ready, cmd_err, pay_ready, pkt_valid, data_out, done, pkt_cnt, err_cnt, state_dbg, IDLE);
    end
    reset = 1'b0;
    exp_pkt_cnt = 0;
    exp_err_cnt = 0;
  endtask

  task automatic test_basic();
    pay_mem[0] = 8'h11; pay_mem[1] = 8'h22; pay_mem[2] = 8'h33;
    load_packet(2'd1, 3, -1, 0, 1'b0);
    n_cmp++;
    if (pkt_valid !== 1'b1 || data_out !== 8'h0D) begin
      n_fail++;
      $display("FAIL header_latency: got pv=%b data=%h, required 1 0d", pkt_valid, data_out);
    end
    collect(-1, 0, 3);
  endtask

  task automatic test_busy_hold();
    pay_mem[0] = 8'h11; pay_mem[1] = 8'h22; pay_mem[2] = 8'h33;
    load_packet(2'd1, 3, -1, 0, 1'b0);
    collect(2, 3, 3);
  endtask

  task automatic test_cmd_err();
    logic [1:0] bad_a [2];
    logic [5:0] bad_l [2];
    bad_a[0] = 2'd3; bad_l[0] = 6'd5;
    bad_a[1] = 2'd0; bad_l[1] = 6'd0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      start = 1'b1; dest_addr = bad_a[c]; pay_len = bad_l[c];
      @(negedge clock);
      start = 1'b0;
      n_cmp++;
      if (cmd_err !== 1'b1 || state_dbg !== IDLE || pkt_valid !== 1'b0 || cmd_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL cmd_err_pulse: case %0d got cerr=%b st=%0d pv=%b rdy=%b, required 1 %0d 0 1",
                 c, cmd_err, state_dbg, pkt_valid, cmd_ready, IDLE);
      end
      @(negedge clock);
      n_cmp++;
      if (cmd_err !== 1'b0 || state_dbg !== IDLE) begin
        n_fail++;
        $display("FAIL cmd_err_width: case %0d got cerr=%b st=%0d, required 0 %0d", c, cmd_err, state_dbg, IDLE);
      end
    end
  endtask

  task automatic test_long_gap();
    for (int i = 0; i < 63; i++) pay_mem[i] = 8'($urandom_range(0, 255));
    load_packet(2'd2, 63, 30, 5, 1'b0);
    collect(-1, 0, 63);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 10; i++) pay_mem[i] = 8'($urandom_range(0, 255));
    load_packet(2'd0, 10, -1, 0, 1'b0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    n_cmp++;
    if (pkt_valid !== 1'b0 || cmd_ready !== 1'b1 || state_dbg !== IDLE || pkt_cnt !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_mid: got pv=%b rdy=%b st=%0d pc=%0d, required 0 1 %0d 0",
               pkt_valid, cmd_ready, state_dbg, pkt_cnt, IDLE);
    end
    reset = 1'b0;
    exp_q.delete();
    exp_pkt_cnt = 0;
    exp_err_cnt = 0;
    pay_mem[0] = 8'($urandom_range(0, 255));
    load_packet(2'd2, 1, -1, 0, 1'b0);
    collect(-1, 0, 1);
  endtask

`ifdef ROUTER_PKT_GEN_PARITY_CORRUPT_EN
  task automatic test_corrupt();
    pay_mem[0] = 8'hAA;
    load_packet(2'd0, 1, -1, 0, 1'b1);
    collect(-1, 0, 1);
    @(negedge clock);
    err = 1'b1;
    @(negedge clock);
    err = 1'b0;
    exp_err_cnt++;
    @(negedge clock);
    n_cmp++;
    if (err_cnt !== 8'(exp_err_cnt)) begin
      n_fail++;
      $display("FAIL corrupt_err_cnt: got %0d, required %0d", err_cnt, exp_err_cnt);
    end
  endtask
`endif

  task automatic test_err_monitor();
    // level high for two cycles is one edge, then one more pulse
    @(negedge clock); err = 1'b1;
    @(negedge clock);
    @(negedge clock); err = 1'b0;
    @(negedge clock); err = 1'b1;
    @(negedge clock); err = 1'b0;
    @(negedge clock);
    exp_err_cnt += 2;
    n_cmp++;
    if (err_cnt !== 8'(exp_err_cnt)) begin
      n_fail++;
      $display("FAIL err_edges: got %0d, required %0d", err_cnt, exp_err_cnt);
    end
    for (int i = 0; i < 300; i++) begin
      err = 1'b1;
      @(negedge clock);
      err = 1'b0;
      @(negedge clock);
      exp_err_cnt = (exp_err_cnt < 255) ? exp_err_cnt + 1 : 255;
    end
    n_cmp++;
    if (err_cnt !== 8'(exp_err_cnt) || err_cnt !== 8'hFF) begin
      n_fail++;
      $display("FAIL err_saturate: got %0d, required %0d", err_cnt, exp_err_cnt);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_busy_hold();
    test_cmd_err();
    test_long_gap();
    test_reset_mid();
`ifdef ROUTER_PKT_GEN_PARITY_CORRUPT_EN
    test_corrupt();
`endif
    test_err_monitor();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
